// File: rtl/fpu_mem_ctrl.sv
// FPU load/store sequencer between the FPU memory stage and the core data-memory port.
// Optional misaligned-address trap: define FPU_MISALIGN_CHECK_EN.
module fpu_mem_ctrl #(
    parameter  int TIMEOUT = 255,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        busy,
    output logic        exception,
    output logic [31:0] exc_addr,
    output logic [31:0] mem_addr,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_store,
    input  logic [31:0] mem_load,
    input  logic        mem_busy,
    output logic        reg_w,
    output logic [4:0]  reg_rd,
    output logic [31:0] reg_wdata
);

    typedef enum logic [1:0] {IDLE, REQ, WB, ERR} state_t;

    state_t             state, state_nx;
    logic [31:0]        addr_q, wdata_q, ldata_q;
    logic [4:0]         rd_q;
    logic               ld_q;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               misal;

    // RST gates acceptance so busy is 0 while reset is held.
    assign accept = (state == IDLE) && !RST && req_valid && (req_load ^ req_store);

`ifdef FPU_MISALIGN_CHECK_EN
    assign misal = accept && (req_addr[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            rd_q    <= '0;
            ld_q    <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                ld_q    <= req_load;
                cnt     <= '0;
            end
            if (state == REQ) begin
                if (mem_busy)
                    cnt <= cnt + CNT_W'(1);
                else if (ld_q)
                    ldata_q <= mem_load;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        exception = 1'b0;
        exc_addr  = '0;
        mem_addr  = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_store = '0;
        reg_w     = 1'b0;
        reg_rd    = '0;
        reg_wdata = '0;
        case (state)
            IDLE: begin
                busy = accept;
                if (accept)
                    state_nx = misal ? ERR : REQ;
            end
            REQ: begin
                busy      = 1'b1;
                mem_addr  = addr_q;
                mem_store = wdata_q;
                mem_ren   = ld_q;
                mem_wen   = !ld_q;
                // Completion is checked first so a drop on the last allowed cycle wins.
                if (!mem_busy) begin
                    if (ld_q) begin
                        state_nx = WB;
                    end else begin
                        state_nx = IDLE;
                        busy     = 1'b0;
                    end
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = ERR;
                end
            end
            WB: begin
                reg_w     = 1'b1;
                reg_rd    = rd_q;
                reg_wdata = ldata_q;
                state_nx  = IDLE;
            end
            ERR: begin
                exception = 1'b1;
                exc_addr  = addr_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpu_mem_ctrl.sv
// Scoreboard bench for fpu_mem_ctrl: driver pushes expectations, monitor pops and checks.
module tb_fpu_mem_ctrl;
    localparam int T = 4;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        req_valid = 0, req_load = 0, req_store = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_load = 0;
    logic [4:0]  req_rd = 0;
    logic        mem_busy = 0;
    logic        busy, exception, mem_ren, mem_wen, reg_w;
    logic [31:0] exc_addr, mem_addr, mem_store, reg_wdata;
    logic [4:0]  reg_rd;

    fpu_mem_ctrl #(.TIMEOUT(T)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_load(req_load),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .busy(busy), .exception(exception), .exc_addr(exc_addr),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_store(mem_store), .mem_load(mem_load), .mem_busy(mem_busy),
        .reg_w(reg_w), .reg_rd(reg_rd), .reg_wdata(reg_wdata));

    always #5 CLK = ~CLK;

    typedef struct {logic wen; logic [31:0] addr; logic [31:0] data; int ncyc;} mreq_t;
    typedef struct {logic exc; logic [4:0] rd; logic [31:0] val;} ev_t;

    mreq_t mq[$];
    ev_t   eq[$];
    bit    bq[$];
    int    tests = 0, fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction plus trailing idle gap; expectations come from the cycle-level rules.
    task automatic do_txn(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int w,
                          input logic [31:0] ldv, input int gap, input bit relrst);
        bit valid, mis, tmo, b;
        int occ;
        valid = ld ^ st;
`ifdef FPU_MISALIGN_CHECK_EN
        mis = valid && (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        tmo = valid && !mis && (w >= T);
        if (!valid) occ = 1;
        else if (mis) begin
            occ = 2;
            eq.push_back('{1'b1, 5'd0, a});
        end else begin
            mq.push_back('{st, a, wd, tmo ? T : w + 1});
            if (tmo) begin
                occ = T + 2;
                eq.push_back('{1'b1, 5'd0, a});
            end else if (ld) begin
                occ = w + 3;
                eq.push_back('{1'b0, rd, ldv});
            end else occ = w + 2;
        end
        for (int c = 0; c < occ + gap; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                if (relrst) RST = 1'b0;
                req_valid = 1'b1; req_load = ld; req_store = st;
                req_addr = a; req_wdata = wd; req_rd = rd;
            end else begin
                req_valid = 1'b0; req_load = $urandom; req_store = $urandom;
                req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
            end
            mem_busy = (c >= 1 && c <= w);
            mem_load = mem_busy ? $urandom : ldv;
            if (c >= occ) b = 0;
            else if (!valid) b = 0;
            else if (mis) b = (c == 0);
            else if (tmo) b = (c <= T);
            else if (ld) b = (c <= w + 1);
            else b = (c <= w);
            bq.push_back(b);
        end
    endtask

    // Load that gets reset in cycle 2, then a load presented in the release cycle.
    task automatic rst_txn();
        mq.push_back('{1'b0, 32'h0000_3000, 32'h1234_5678, 1});
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            req_valid = (c == 0); req_load = 1'b1; req_store = 1'b0;
            req_addr = 32'h0000_3000; req_wdata = 32'h1234_5678; req_rd = 5'd9;
            mem_busy = (c >= 1);
            if (c == 2) RST = 1'b1;
            bq.push_back(c < 2);
        end
        do_txn(1, 0, 32'h0000_3010, 32'h0, 5'd11, 1, 32'hCAFE_F00D, 0, 1);
    endtask

    // Monitor: compares DUT outputs against queued expectations every cycle.
    initial begin
        mreq_t cur;
        ev_t   e;
        logic  pen = 1'b0;
        int    ncnt = 0;
        bit    eb;
        cur = '{1'b0, 32'h0, 32'h0, 0};
        forever begin
            @(negedge CLK);
            #2;
            eb = (bq.size() > 0) ? bq.pop_front() : 1'b0;
            chk("busy", 128'(busy), 128'(eb));
            if (RST)
                chk("reset_zero", {busy, exception, exc_addr, mem_addr, mem_ren, mem_wen,
                                   mem_store, reg_w, reg_rd, reg_wdata}, '0);
            chk("idle_zero", {reg_w ? 37'h0 : {reg_rd, reg_wdata},
                              exception ? 32'h0 : exc_addr,
                              (mem_ren | mem_wen) ? 64'h0 : {mem_addr, mem_store}}, '0);
            if (mem_ren || mem_wen) begin
                if (!pen) begin
                    ncnt = 0;
                    if (mq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL mem_req: unexpected request addr %0h at %0t", mem_addr, $time);
                    end else cur = mq.pop_front();
                end
                ncnt++;
                chk("mem_req", {mem_ren, mem_wen, mem_addr, mem_store},
                    {!cur.wen, cur.wen, cur.addr, cur.data});
            end else if (pen) begin
                chk("mem_req_len", 128'(ncnt), 128'(cur.ncyc));
            end
            pen = mem_ren | mem_wen;
            if (reg_w || exception) begin
                chk("one_event", {reg_w, exception} == 2'b11, 0);
                if (eq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL event: unexpected reg_w=%0b exception=%0b at %0t", reg_w, exception, $time);
                end else begin
                    e = eq.pop_front();
                    if (e.exc) chk("exception", {exception, exc_addr}, {1'b1, e.val});
                    else       chk("reg_write", {reg_w, reg_rd, reg_wdata}, {1'b1, e.rd, e.val});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, k;
        logic [31:0] a;
        repeat (3) @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        bq.push_back(1'b0);
        do_txn(1, 0, 32'h0000_1000, 32'h0, 5'd5, 0, 32'h3F80_0000, 1, 0);
        do_txn(0, 1, 32'h0000_2004, 32'hDEAD_BEEF, 5'd0, 3, 32'h0, 1, 0);
        do_txn(1, 0, 32'h0000_1000, 32'h0, 5'd7, T, 32'h1111_2222, 1, 0);
        do_txn(1, 0, 32'h0000_1000, 32'h0, 5'd8, T - 1, 32'h3333_4444, 1, 0);
        do_txn(1, 1, 32'h0000_4000, 32'h5, 5'd1, 0, 32'h0, 1, 0);
        do_txn(0, 0, 32'h0000_4000, 32'h5, 5'd1, 0, 32'h0, 1, 0);
        do_txn(0, 1, 32'h0000_2002, 32'hA5A5_5A5A, 5'd0, 1, 32'h0, 1, 0);
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 9);
            w = (k == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, T - 1);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_txn((k < 5) || (k == 9), (k >= 5), a, $urandom, 5'($urandom), w, $urandom,
                   $urandom_range(0, 2), 0);
        end
        rst_txn();
        repeat (4) begin
            @(negedge CLK);
            bq.push_back(1'b0);
        end
        @(negedge CLK);
        #3;
        chk("events_drained", 128'(eq.size()), 0);
        chk("mem_drained", 128'(mq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpu_mem_ctrl.md
# fpu_mem_ctrl

Sequencer for FPU load/store traffic between the FPU memory stage and the core data-memory port exposed through risc_mgmt. It accepts one FP load/store per transaction and holds the memory request stable until the memory side completes. It stalls the FPU pipeline while the transaction is outstanding, captures load data, issues a single-cycle FP register write, and raises an exception on a memory timeout or a misaligned address.

## Interface
- TIMEOUT, 255: max consecutive `mem_busy` cycles in REQ before abort; legal range 1..65535
- CNT_W, $clog2(TIMEOUT+1): timeout counter width (derived, do not override)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req_valid  in  1  FPU memory stage presents an operation
- req_load  in  1  operation is FP load
- req_store  in  1  operation is FP store
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_rd  in  5  FP destination register for loads
- busy  out  1  stall to FPU pipeline
- exception  out  1  one-cycle exception pulse
- exc_addr  out  32  faulting address, valid while `exception`=1
- mem_addr  out  32  memory address
- mem_ren  out  1  read request
- mem_wen  out  1  write request
- mem_store  out  32  write data
- mem_load  in  32  read data, valid in the cycle `mem_busy`=0 with `mem_ren`=1
- mem_busy  in  1  memory not yet done; transfer completes in any cycle with request high and `mem_busy`=0
- reg_w  out  1  FP register write enable
- reg_rd  out  5  FP register write index
- reg_wdata  out  32  FP register write data

## Operation
- States: IDLE, REQ, WB, ERR. Reset → IDLE; counter, latches and all outputs are 0.
- A request is accepted only in IDLE. The request must have `req_valid`=1 and exactly one of `req_load`/`req_store` set.
  - On acceptance, latch addr, wdata, rd and type, clear the counter, and go to REQ.
  - An invalid request (both type bits set, or neither) is ignored. `busy`=0 and no memory access occurs.
- REQ:
  - `mem_addr`, `mem_store` and `mem_ren`/`mem_wen` are driven from the latches. Exactly one enable is high, held constant.
  - `mem_busy`=0, load: capture `mem_load`, go to WB.
  - `mem_busy`=0, store: go to IDLE.
  - `mem_busy`=1: counter +1. When the counter equals TIMEOUT, go to ERR. The enables are low from the next cycle.
- WB: `reg_w`=1, `reg_rd`=latched rd, `reg_wdata`=captured data, for exactly one cycle, then go to IDLE.
- ERR: `exception`=1 and `exc_addr`=latched addr for one cycle, then go to IDLE. No register write occurs.
- Memory outputs are 0 in IDLE, WB and ERR. `reg_*` outputs are 0 outside WB.
- `busy` equations:
  - IDLE: `busy` = request accepted this cycle.
  - REQ: `busy` = 1, except 0 in the store-completion cycle.
  - WB and ERR: `busy` = 0.
- Inputs are ignored in every state except IDLE. The pipeline holds its request stable while `busy`=1.

## Timing
- Acceptance at cycle 0 (combinational `busy`); the memory request is visible from cycle 1.
- Zero-wait memory:
  - store completes in cycle 1, `busy` low in cycle 1;
  - load completes in cycle 1, `reg_w` in cycle 2.
- Each wait cycle adds one cycle of latency.
- Back-to-back operations: the next request is accepted no earlier than the cycle after the store completion or after WB. Minimum spacing is 2 cycles for stores and 3 cycles for loads.
- Timeout: with `mem_busy` stuck at 1, `exception` pulses in cycle TIMEOUT+1 after acceptance.
- `mem_busy` dropping in the same cycle the counter reaches TIMEOUT counts as completion, not timeout; completion wins.
- RST asserted mid-transaction: immediate return to IDLE with all outputs 0. No pending write or exception survives.

## Configuration
- FPU_MISALIGN_CHECK_EN
  - Defined: an accepted request with `req_addr[1:0]`≠0 goes IDLE → ERR directly. No memory request is issued, `busy`=1 in the accept cycle, and `exception` pulses in cycle 1 with `exc_addr`=req_addr.
  - Undefined: no alignment check; the address is passed to memory unmodified.

## Test plan
- Load 0x1000, rd=5, `mem_busy`=0, `mem_load`=0x3F800000 → `mem_ren`=1 cycle 1; `reg_w`=1, `reg_rd`=5, `reg_wdata`=0x3F800000 in cycle 2; `busy` low in cycle 2.
- Store 0x2004, data 0xDEADBEEF, `mem_busy`=1 for 3 cycles → `mem_wen`/`mem_addr`/`mem_store` stable cycles 1-4; `busy`=0 in cycle 4; no `reg_w`.
- TIMEOUT=4, load with `mem_busy` stuck at 1 → `exception`=1 with `exc_addr`=0x1000 in cycle 5; `mem_ren`=0 from cycle 5; IDLE in cycle 6. Repeat with `mem_busy` dropping in cycle 4 → load completes, no exception.
- `req_valid` with both `req_load`=`req_store`=1, then neither → `busy`=0, no memory enables, no `reg_w`.
- With FPU_MISALIGN_CHECK_EN, store to 0x2002 → no `mem_wen` ever; `exception`=1 and `exc_addr`=0x2002 in cycle 1. Without the macro → normal store to 0x2002.
- RST pulsed in cycle 2 of a waiting load → all outputs 0 immediately; no `reg_w` after release; a new load is accepted in the first cycle after reset.
